// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants and the instruction queue entry type
package cpu_pkg;

    localparam int ILEN = 32;
    localparam int XLEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - multi-push / multi-pop instruction queue between fetch and decode
// First-word fall-through ring; DEPTH must be a power of 2 and >= FETCH_W+ISSUE_W.
module inst_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [$clog2(FETCH_W+1)-1:0]       in_cnt,
    input  logic [FETCH_W*ILEN-1:0]            in_inst,
    input  logic [XLEN-1:0]                    in_pc,
    output logic [ISSUE_W-1:0]                 out_valid,
    output logic [ISSUE_W*ILEN-1:0]            out_inst,
    output logic [ISSUE_W*XLEN-1:0]            out_pc,
    input  logic [$clog2(ISSUE_W+1)-1:0]       out_take,
    output logic [$clog2(DEPTH+1)-1:0]         count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int ICW = $clog2(FETCH_W+1);
    localparam int TW  = $clog2(ISSUE_W+1);

    iq_entry_t       ring [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push;
    logic [ICW-1:0]  pushed;
    logic [TW-1:0]   take_lim;
    logic [TW-1:0]   popped;

    // in_ready looks only at the registered count so take/flush never reach it
    always_comb begin
        in_ready = (count <= CW'(DEPTH - FETCH_W));
        push     = in_valid && in_ready && !flush;
        pushed   = '0;
        if (push) begin
            pushed = (in_cnt > ICW'(FETCH_W)) ? ICW'(FETCH_W) : in_cnt;
        end
        take_lim = (out_take > TW'(ISSUE_W)) ? TW'(ISSUE_W) : out_take;
        popped   = (CW'(take_lim) > count) ? TW'(count) : take_lim;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(popped);
            wr_ptr <= wr_ptr + PW'(pushed);
            count  <= count + CW'(pushed) - CW'(popped);
        end
    end

    // Entry storage is deliberately left unreset; validity comes from count alone
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (ICW'(i) < pushed) begin
                ring[wr_ptr + PW'(i)] <= '{inst: in_inst[i*ILEN +: ILEN],
                                           pc:   in_pc + XLEN'(i) * PC_STEP};
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k] = (count > CW'(k));
            if (out_valid[k]) begin
                out_inst[k*ILEN +: ILEN] = ring[rd_ptr + PW'(k)].inst;
                out_pc[k*XLEN +: XLEN]   = ring[rd_ptr + PW'(k)].pc;
            end else begin
                out_inst[k*ILEN +: ILEN] = NOP_INST;
                out_pc[k*XLEN +: XLEN]   = '0;
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue against a queue-based reference model
module tb_inst_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int IW    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cnt;
    logic [63:0] in_inst;
    logic [31:0] in_pc;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  out_take;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] next_pc;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];

    inst_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_cnt(in_cnt), .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (in_valid)
                assert (in_cnt <= FW) else $error("assert: in_cnt=%0d exceeds FETCH_W", in_cnt);
            assert (int'(out_take) <= $countones(out_valid))
                else $error("assert: out_take=%0d exceeds valid lanes", out_take);
        end
    end

    function automatic logic [31:0] m_inst(int k);
        return (k < q.size()) ? q[k].inst : NOP_INST;
    endfunction

    function automatic logic [31:0] m_pc(int k);
        return (k < q.size()) ? q[k].pc : 32'h0;
    endfunction

    function automatic logic [1:0] m_valid();
        logic [1:0] v;
        for (int k = 0; k < IW; k++) v[k] = (k < q.size());
        return v;
    endfunction

    // Advance one clock; the model applies the queue rules to the inputs present at the edge
    task automatic cycle();
        int  sz;
        int  pop_n;
        bit  ready;
        sz    = q.size();
        ready = (DEPTH - sz) >= FW;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            pop_n = int'(out_take);
            if (pop_n > sz) pop_n = sz;
            if (pop_n > IW) pop_n = IW;
            repeat (pop_n) void'(q.pop_front());
            if (in_valid && ready)
                for (int i = 0; i < int'(in_cnt); i++)
                    q.push_back('{inst: in_inst[32*i +: 32], pc: in_pc + 32'(4*i)});
        end
        #1;
    endtask

    task automatic drive_push(input logic [1:0] cnt);
        in_valid = 1'b1;
        in_cnt   = cnt;
        in_inst  = {$urandom, $urandom};
        in_pc    = next_pc;
        next_pc  = next_pc + 32'(4*int'(cnt));
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cnt = '0;
        in_inst = '0; in_pc = '0; out_take = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_inst[31:0] !== NOP_INST) begin n_fail++; $display("FAIL reset_nop got=%h exp=%h", out_inst[31:0], NOP_INST); end
        @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_cnt = 2'd2; in_pc = 32'h1000;
        in_inst  = {32'h0010_0113, 32'h00A0_0093};
        out_take = 2'd0;
        #1;
        n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL no_bypass got=%b exp=00", out_valid); end
        cycle();
        in_valid = 1'b0;
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", count); end
        n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got=%b exp=11", out_valid); end
        n_checks++; if (out_pc !== {32'h1004, 32'h1000}) begin n_fail++; $display("FAIL basic_pc got=%h exp=%h", out_pc, {32'h1004, 32'h1000}); end
        n_checks++; if (out_inst !== {32'h0010_0113, 32'h00A0_0093}) begin n_fail++; $display("FAIL basic_inst got=%h", out_inst); end
        out_take = 2'd1;
        cycle();
        out_take = 2'd0;
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL pop1_count got=%0d exp=1", count); end
        n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL pop1_valid got=%b exp=01", out_valid); end
        n_checks++; if (out_inst !== {NOP_INST, 32'h0010_0113}) begin n_fail++; $display("FAIL pop1_inst got=%h", out_inst); end
        n_checks++; if (out_pc !== {32'h0, 32'h1004}) begin n_fail++; $display("FAIL pop1_pc got=%h", out_pc); end
    endtask

    task automatic test_fill_full();
        next_pc  = 32'h1008;
        out_take = 2'd1;
        cycle();
        out_take = 2'd0;
        for (int i = 0; i < 3; i++) begin
            drive_push(2'd2);
            cycle();
            n_checks++; if (count !== 4'(2*(i+1))) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, 2*(i+1)); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
        end
        drive_push(2'd2);
        cycle();
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got=%0d exp=8", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        in_inst = {$urandom, $urandom};
        cycle();
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=8", count); end
        n_checks++; if (out_inst !== {m_inst(1), m_inst(0)}) begin n_fail++; $display("FAIL full_hold_inst got=%h exp=%h", out_inst, {m_inst(1), m_inst(0)}); end
        n_checks++; if (out_pc !== {m_pc(1), m_pc(0)}) begin n_fail++; $display("FAIL full_hold_pc got=%h exp=%h", out_pc, {m_pc(1), m_pc(0)}); end
        next_pc = in_pc + 32'd8;
        in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_head;
        out_take = 2'd2;
        cycle();
        exp_head = q[0].pc;
        for (int c = 0; c < 10; c++) begin
            drive_push(2'd2);
            out_take = 2'd2;
            cycle();
            exp_head = exp_head + 32'd8;
            n_checks++; if (count !== 4'd6) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=6", c, count); end
            n_checks++; if (out_pc !== {exp_head + 32'd4, exp_head}) begin n_fail++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", c, out_pc, {exp_head + 32'd4, exp_head}); end
            n_checks++; if (out_inst !== {m_inst(1), m_inst(0)}) begin n_fail++; $display("FAIL wrap_inst[%0d] got=%h exp=%h", c, out_inst, {m_inst(1), m_inst(0)}); end
        end
        in_valid = 1'b0; out_take = 2'd0;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive_push(2'd2); cycle();
        drive_push(2'd2); cycle();
        drive_push(2'd1); cycle();
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
        drive_push(2'd2);
        out_take = 2'd2;
        flush    = 1'b1;
        cycle();
        flush = 1'b0; out_take = 2'd0; in_valid = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid got=%b exp=00", out_valid); end
        in_valid = 1'b1; in_cnt = 2'd1; in_pc = 32'h3000; in_inst = {$urandom, 32'hDEAD_0013};
        cycle();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL post_flush_valid got=%b exp=01", out_valid); end
        n_checks++; if (out_pc[31:0] !== 32'h3000) begin n_fail++; $display("FAIL post_flush_pc got=%h exp=3000", out_pc[31:0]); end
        n_checks++; if (out_inst[31:0] !== 32'hDEAD_0013) begin n_fail++; $display("FAIL post_flush_inst got=%h exp=dead0013", out_inst[31:0]); end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive_push(2'd2); cycle();
        drive_push(2'd2); cycle();
        in_valid = 1'b0;
        n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=4", count); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", count); end
        n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL areset_valid got=%b exp=00", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready got=%b exp=1", in_ready); end
        q.delete();
        #1;
        reset = 1'b0;
        in_valid = 1'b1; in_cnt = 2'd1; in_pc = 32'h2000; in_inst = {$urandom, $urandom};
        cycle();
        in_valid = 1'b0;
        n_checks++; if (out_pc !== {32'h0, 32'h2000}) begin n_fail++; $display("FAIL areset_push_pc got=%h exp=%h", out_pc, {32'h0, 32'h2000}); end
        n_checks++; if (out_inst[63:32] !== NOP_INST) begin n_fail++; $display("FAIL areset_lane1_nop got=%h exp=%h", out_inst[63:32], NOP_INST); end
        n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL areset_push_valid got=%b exp=01", out_valid); end
    endtask

    task automatic test_random();
        int lim;
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) != 0) drive_push(2'($urandom_range(0, 2)));
            else in_valid = 1'b0;
            lim = (q.size() < IW) ? q.size() : IW;
            out_take = 2'($urandom_range(0, lim));
            cycle();
            n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
            n_checks++; if (in_ready !== ((DEPTH - q.size()) >= FW)) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b", c, in_ready); end
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, out_valid, m_valid()); end
            for (int k = 0; k < IW; k++) begin
                n_checks++; if (out_inst[32*k +: 32] !== m_inst(k)) begin n_fail++; $display("FAIL rand_inst[%0d][%0d] got=%h exp=%h", c, k, out_inst[32*k +: 32], m_inst(k)); end
                n_checks++; if (out_pc[32*k +: 32] !== m_pc(k)) begin n_fail++; $display("FAIL rand_pc[%0d][%0d] got=%h exp=%h", c, k, out_pc[32*k +: 32], m_pc(k)); end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_take = 2'd0;
    endtask

    initial begin
        next_pc = 32'h0;
        test_reset();
        test_basic();
        test_fill_full();
        test_wrap();
        test_flush();
        test_async_reset();
        next_pc = 32'h8000;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
